// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : ALU control codes, flag selects and arbiter state type.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [2:0] FS_EQ  = 3'b000;
    localparam logic [2:0] FS_NE  = 3'b001;
    localparam logic [2:0] FS_LT  = 3'b100;
    localparam logic [2:0] FS_GE  = 3'b101;
    localparam logic [2:0] FS_LTU = 3'b110;
    localparam logic [2:0] FS_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick: first valid above i_last, wrapping.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Two ascending passes: indices above the last winner, then the wrapped rest.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && (i > int'(i_last)) && i_valid[i]) begin
                o_grant[i] = 1'b1;
                o_idx      = ID_W'(i);
                o_any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && (i <= int'(i_last)) && i_valid[i]) begin
                o_grant[i] = 1'b1;
                o_idx      = ID_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one combinational RV32 ALU between
//           NUM_REQ requesters. Optional macro ALU_ARB_STATS_EN adds
//           per-requester saturating grant counters on Grant_cnt_o.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                   Clk_i,
    input  logic                   Rst_ni,
    input  logic [NUM_REQ-1:0]     Req_valid_i,
    output logic [NUM_REQ-1:0]     Req_ready_o,
    input  logic [NUM_REQ*32-1:0]  Req_opA_i,
    input  logic [NUM_REQ*32-1:0]  Req_opB_i,
    input  logic [NUM_REQ*4-1:0]   Req_ctrl_i,
    input  logic [NUM_REQ*3-1:0]   Req_flagsel_i,
    output logic [31:0]            Alu_opA_o,
    output logic [31:0]            Alu_opB_o,
    output logic [3:0]             Alu_ctrl_o,
    output logic [2:0]             Alu_flagsel_o,
    input  logic [31:0]            Alu_result_i,
    input  logic                   Alu_flag_i,
    output logic                   Rsp_valid_o,
    input  logic                   Rsp_ready_i,
    output logic [ID_W-1:0]        Rsp_id_o,
    output logic [31:0]            Rsp_result_o,
    output logic                   Rsp_flag_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] Grant_cnt_o
`endif
);

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (CNT_W < 1)) begin : g_bad_params
        $error("alu_arbiter: NUM_REQ must be 2..8 and CNT_W at least 1");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [ID_W-1:0]    r_last;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_accept;

    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [3:0]         r_ctrl;
    logic [2:0]         r_fsel;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_flag;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_valid (Req_valid_i),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        Req_ready_o = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                Req_ready_o = w_grant;
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (Rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            r_last       <= ID_W'(NUM_REQ - 1);
            r_opa        <= '0;
            r_opb        <= '0;
            r_ctrl       <= '0;
            r_fsel       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flag   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opa    <= Req_opA_i[w_idx*32 +: 32];
                r_opb    <= Req_opB_i[w_idx*32 +: 32];
                r_ctrl   <= Req_ctrl_i[w_idx*4 +: 4];
                r_fsel   <= Req_flagsel_i[w_idx*3 +: 3];
                r_last   <= w_idx;
                r_rsp_id <= w_idx;
            end
            // The ALU settles during EXEC from the operands latched at accept.
            if (r_state == EXEC) begin
                r_rsp_result <= Alu_result_i;
                r_rsp_flag   <= Alu_flag_i;
                r_rsp_valid  <= 1'b1;
            end
            if ((r_state == RESP) && Rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign Alu_opA_o     = r_opa;
    assign Alu_opB_o     = r_opb;
    assign Alu_ctrl_o    = r_ctrl;
    assign Alu_flagsel_o = r_fsel;
    assign Rsp_valid_o   = r_rsp_valid;
    assign Rsp_id_o      = r_rsp_id;
    assign Rsp_result_o  = r_rsp_result;
    assign Rsp_flag_o    = r_rsp_flag;

`ifdef ALU_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge Clk_i or negedge Rst_ni) begin
            if (!Rst_ni) begin
                r_cnt <= '0;
            end else if (w_accept && w_grant[g] && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign Grant_cnt_o[g*CNT_W +: CNT_W] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Self-checking bench: behavioural ALU plus transaction-level model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int N    = 2;
    localparam int ID_W = $clog2(N);

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       vld;
    logic [N-1:0]       rdy;
    logic [N*32-1:0]    opa;
    logic [N*32-1:0]    opb;
    logic [N*4-1:0]     ctrl;
    logic [N*3-1:0]     fs;
    logic [31:0]        alu_a, alu_b, alu_res;
    logic [3:0]         alu_c;
    logic [2:0]         alu_fs;
    logic               alu_flag;
    logic               rsp_valid, rsp_rdy, rsp_flag;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_res;
`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0]    gcnt;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .Clk_i         (clk),
        .Rst_ni        (rst_n),
        .Req_valid_i   (vld),
        .Req_ready_o   (rdy),
        .Req_opA_i     (opa),
        .Req_opB_i     (opb),
        .Req_ctrl_i    (ctrl),
        .Req_flagsel_i (fs),
        .Alu_opA_o     (alu_a),
        .Alu_opB_o     (alu_b),
        .Alu_ctrl_o    (alu_c),
        .Alu_flagsel_o (alu_fs),
        .Alu_result_i  (alu_res),
        .Alu_flag_i    (alu_flag),
        .Rsp_valid_o   (rsp_valid),
        .Rsp_ready_i   (rsp_rdy),
        .Rsp_id_o      (rsp_id),
        .Rsp_result_o  (rsp_res),
        .Rsp_flag_o    (rsp_flag)
`ifdef ALU_ARB_STATS_EN
        ,
        .Grant_cnt_o   (gcnt)
`endif
    );

    function automatic logic [31:0] f_res(logic [31:0] a, logic [31:0] b, logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return a ^ b;
            4'd4:    return a >> b[4:0];
            4'd5:    return $unsigned($signed(a) >>> b[4:0]);
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return b << 12;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic f_flag(logic [31:0] a, logic [31:0] b, logic [2:0] f);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign alu_res  = f_res(alu_a, alu_b, alu_c);
    assign alu_flag = f_flag(alu_a, alu_b, alu_fs);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: stage 0 = free, 1 = accepted last edge, 2 = response held.
    int          m_stage, m_last, m_acc_id, acc_prev, cyc;
    bit          m_acc, m_rdy_edge;
    int          e_id;
    logic [31:0] e_res;
    logic        e_flag;
    int          g_id[$];
    int          g_cyc[$];

    function automatic int pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_stage    = 0;
        m_last     = N - 1;
        m_acc      = 0;
        m_rdy_edge = 0;
    endtask

    task automatic set_req(int r, logic [31:0] a, logic [31:0] b, logic [3:0] c, logic [2:0] f);
        vld[r]            = 1'b1;
        opa[r*32 +: 32]   = a;
        opb[r*32 +: 32]   = b;
        ctrl[r*4 +: 4]    = c;
        fs[r*3 +: 3]      = f;
    endtask

    task automatic rand_req(int r);
        logic [31:0] a, b;
        logic [2:0]  f;
        b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        a = ($urandom_range(0, 3) == 0) ? b : $urandom;
        case ($urandom_range(0, 5))
            0: f = 3'b000;
            1: f = 3'b001;
            2: f = 3'b100;
            3: f = 3'b101;
            4: f = 3'b110;
            default: f = 3'b111;
        endcase
        set_req(r, a, b, 4'($urandom_range(0, 8)), f);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        acc_prev = -1;
        if (m_stage == 0 && m_acc) begin
            m_stage  = 1;
            acc_prev = m_acc_id;
        end else if (m_stage == 1) begin
            m_stage = 2;
        end else if (m_stage == 2 && m_rdy_edge) begin
            m_stage = 0;
        end
        m_acc = 0;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
        if (m_stage == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(e_id));
            chk("rsp_result", rsp_res, e_res);
            chk("rsp_flag", 32'(rsp_flag), 32'(e_flag));
        end
    endtask

    task automatic settle();
        int w;
        logic [N-1:0] er;
        #1;
        w  = (m_stage == 0) ? pick(vld, m_last) : -1;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 32'(rdy), 32'(er));
        if (w >= 0) begin
            m_acc    = 1;
            m_acc_id = w;
            m_last   = w;
            e_id     = w;
            e_res    = f_res(opa[w*32 +: 32], opb[w*32 +: 32], ctrl[w*4 +: 4]);
            e_flag   = f_flag(opa[w*32 +: 32], opb[w*32 +: 32], fs[w*3 +: 3]);
            g_id.push_back(w);
            g_cyc.push_back(cyc);
        end
        m_rdy_edge = rsp_rdy;
    endtask

    task automatic dir(int r, logic [31:0] a, logic [31:0] b, logic [3:0] c, logic [2:0] f,
                       logic [31:0] er, logic ef);
        tick();
        vld = '0;
        set_req(r, a, b, c, f);
        rsp_rdy = 1'b1;
        settle();
        chk("dir_ready", 32'(rdy), 32'(1) << r);
        tick();
        vld = '0;
        settle();
        tick();
        chk("dir_id", 32'(rsp_id), 32'(r));
        chk("dir_result", rsp_res, er);
        chk("dir_flag", 32'(rsp_flag), 32'(ef));
        settle();
    endtask

    initial begin
        int s;
        rst_n = 1'b0; vld = '0; opa = '0; opb = '0; ctrl = '0; fs = '0; rsp_rdy = 1'b0;
        cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_result", rsp_res, 0);
        chk("reset_rsp_flag", 32'(rsp_flag), 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_ctrl", 32'(alu_c), 0);
        chk("reset_alu_fs", 32'(alu_fs), 0);
        rst_n = 1'b1;
        model_reset();
        settle();

        dir(0, 32'd5, 32'd7, 4'b0000, 3'b000, 32'd12, 1'b0);
        dir(1, 32'd3, 32'd3, 4'b0001, 3'b000, 32'd0, 1'b1);
        dir(1, 32'd3, 32'd3, 4'b0001, 3'b001, 32'd0, 1'b0);
        dir(0, 32'hFFFF_FFFF, 32'd1, 4'b0001, 3'b100, 32'hFFFF_FFFE, 1'b1);
        dir(0, 32'hFFFF_FFFF, 32'd1, 4'b0001, 3'b110, 32'hFFFF_FFFE, 1'b0);

        // Backpressure with both requesters pending behind a held response.
        tick();
        vld = '0;
        set_req(0, 32'd9, 32'd4, 4'b0000, 3'b000);
        rsp_rdy = 1'b0;
        settle();
        tick();
        vld = '0;
        settle();
        tick();
        rand_req(0);
        rand_req(1);
        settle();
        repeat (4) begin
            tick();
            chk("bp_result", rsp_res, 32'd13);
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_ready", 32'(rdy), 0);
            settle();
        end
        tick();
        rsp_rdy = 1'b1;
        settle();
        tick();
        chk("bp_released", 32'(rsp_valid), 0);
        vld = '0;
        settle();

        // Reset pulse while a request sits in EXEC.
        tick();
        set_req(0, 32'h55, 32'h3, 4'b0000, 3'b000);
        rsp_rdy = 1'b1;
        settle();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", rsp_res, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
`ifdef ALU_ARB_STATS_EN
        chk("rst_grant_cnt", gcnt, 0);
`endif
        vld = '0;
        rand_req(0);
        rand_req(1);
        settle();
        chk("rst_first_winner", 32'(rdy), 1);
        s = g_id.size() - 1;

        // Both valid continuously: strict alternation, one grant every 3 cycles.
        repeat (15) begin
            tick();
            if (acc_prev >= 0) rand_req(acc_prev);
            settle();
        end
        chk("rot_count", 32'(g_id.size() >= s + 5), 1);
        if (g_id.size() >= s + 5) begin
            for (int k = s; k < s + 5; k++) begin
                chk("rot_id", 32'(g_id[k]), 32'((k - s) % 2));
                if (k > s) chk("rot_gap", 32'(g_cyc[k] - g_cyc[k-1]), 3);
            end
        end

        // Randomized traffic and backpressure.
        repeat (400) begin
            tick();
            if (acc_prev >= 0) begin
                if ($urandom_range(0, 3) != 0) rand_req(acc_prev);
                else vld[acc_prev] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
            end
            rsp_rdy = ($urandom_range(0, 9) < 7);
            settle();
        end

        tick();
        vld = '0;
        rsp_rdy = 1'b1;
        settle();
        repeat (4) begin
            tick();
            settle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
